// File: rtl/pkg_dtypes.sv
// rtl/pkg_dtypes.sv - shared datapath types for dispatch, EU queues and operand cache
package pkg_dtypes;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  dst;
      logic [4:0]  src0;
      logic [4:0]  src1;
      logic [10:0] imm;
   } type_iqueue_entry;

endpackage

// File: rtl/design_parameters.sv
// rtl/design_parameters.sv - global sizing macros shared across the EU datapath
`ifndef DESIGN_PARAMETERS_SV
`define DESIGN_PARAMETERS_SV

`define EU_IQUEUE_NUM_IDX_BITS 2

`endif

// File: rtl/eu_iqueue.sv
// rtl/eu_iqueue.sv - in-order per-EU instruction queue feeding the operand cache
`ifndef EU_IQUEUE_NUM_IDX_BITS
`define EU_IQUEUE_NUM_IDX_BITS 2
`endif

module eu_iqueue
   import pkg_dtypes::*;
#(
   parameter int unsigned NUM_IDX_BITS   = `EU_IQUEUE_NUM_IDX_BITS,
   parameter int unsigned STALL_CNT_BITS = 8,
   parameter int unsigned EU_IDX         = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  type_iqueue_entry          instr_i,
   input  logic                      instr_valid_i,
   output logic                      instr_ready_o,
   output type_iqueue_entry          curr_instr_o,
   output logic                      curr_instr_valid_o,
   input  logic                      retire_i,
   input  logic                      flush_i,
   output logic [NUM_IDX_BITS:0]     count_o,
   output logic [STALL_CNT_BITS-1:0] stall_cnt_o,
   output logic                      stall_timeout_o,
   output logic                      retire_err_o
);

   // EU_IDX is debug-only; folded in with zero weight so it stays referenced.
   localparam int unsigned DEPTH = (2 ** NUM_IDX_BITS) + 0 * EU_IDX;
   localparam logic [NUM_IDX_BITS:0]     CNT_FULL  = (NUM_IDX_BITS + 1)'(DEPTH);
   localparam logic [NUM_IDX_BITS:0]     CNT_ONE   = (NUM_IDX_BITS + 1)'(1);
   localparam logic [NUM_IDX_BITS-1:0]   PTR_ONE   = NUM_IDX_BITS'(1);
   localparam logic [STALL_CNT_BITS-1:0] STALL_ONE = STALL_CNT_BITS'(1);
   localparam logic [STALL_CNT_BITS-1:0] STALL_MAX = '1;

   type_iqueue_entry            mem [DEPTH];
   logic [NUM_IDX_BITS-1:0]     wr_ptr;
   logic [NUM_IDX_BITS-1:0]     rd_ptr;
   logic [NUM_IDX_BITS:0]       count;
   logic [STALL_CNT_BITS-1:0]   stall_cnt;
   logic                        retire_err;
   logic                        not_empty;
   logic                        do_push;
   logic                        do_retire;

   assign not_empty = (count != '0);
   assign do_push   = instr_valid_i & instr_ready_o & ~flush_i;
   assign do_retire = retire_i & not_empty & ~flush_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         stall_cnt <= '0;
      end else if (flush_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         stall_cnt <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_retire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_retire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // Counts how long the present head has been waiting; a new head starts from zero.
         if (not_empty && !retire_i) begin
            stall_cnt <= (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_ONE;
         end else begin
            stall_cnt <= '0;
         end
      end
   end

   // Sticky across flush so a spurious retire is still visible when debugging.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_err <= 1'b0;
      end else if (retire_i && !not_empty) begin
         retire_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= instr_i;
      end
   end

   assign instr_ready_o      = (count != CNT_FULL);
   assign curr_instr_valid_o = not_empty;
   assign curr_instr_o       = not_empty ? mem[rd_ptr] : '0;
   assign count_o            = count;
   assign stall_cnt_o        = stall_cnt;
   assign stall_timeout_o    = (stall_cnt == STALL_MAX);
   assign retire_err_o       = retire_err;

endmodule

// File: tb/tb_eu_iqueue.sv
// tb/tb_eu_iqueue.sv - self-checking bench for eu_iqueue
module tb_eu_iqueue;
   import pkg_dtypes::*;

   localparam int NIB   = 2;
   localparam int SCB   = 3;
   localparam int DEPTH = 4;
   localparam int SMAX  = 7;

   logic             clk = 1'b0;
   logic             reset;
   type_iqueue_entry instr_i;
   logic             instr_valid_i;
   logic             instr_ready_o;
   type_iqueue_entry curr_instr_o;
   logic             curr_instr_valid_o;
   logic             retire_i;
   logic             flush_i;
   logic [NIB:0]     count_o;
   logic [SCB-1:0]   stall_cnt_o;
   logic             stall_timeout_o;
   logic             retire_err_o;

   int total = 0;
   int bad   = 0;

   type_iqueue_entry mq[$];
   int               mstall;
   bit               merr;

   typedef struct {
      logic        vld;
      logic [31:0] d;
      logic        ret;
      logic        fl;
      int          e_cnt;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_head;
      int          e_stall;
   } vec_t;

   vec_t tbl[7];

   eu_iqueue #(
      .NUM_IDX_BITS   (NIB),
      .STALL_CNT_BITS (SCB),
      .EU_IDX         (0)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .instr_i            (instr_i),
      .instr_valid_i      (instr_valid_i),
      .instr_ready_o      (instr_ready_o),
      .curr_instr_o       (curr_instr_o),
      .curr_instr_valid_o (curr_instr_valid_o),
      .retire_i           (retire_i),
      .flush_i            (flush_i),
      .count_o            (count_o),
      .stall_cnt_o        (stall_cnt_o),
      .stall_timeout_o    (stall_timeout_o),
      .retire_err_o       (retire_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: a plain FIFO of entries plus a wait counter for its head.
   task automatic model_edge(input logic vld, input type_iqueue_entry d, input logic ret, input logic fl);
      int  sz;
      bit  had_head;
      sz = mq.size();
      had_head = (sz != 0);
      if (ret && sz == 0) merr = 1'b1;
      if (fl) begin
         mq.delete();
         mstall = 0;
      end else begin
         mstall = (had_head && !ret) ? ((mstall < SMAX) ? mstall + 1 : SMAX) : 0;
         if (ret && had_head) void'(mq.pop_front());
         if (vld && sz != DEPTH) mq.push_back(d);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mstall = 0;
      merr   = 1'b0;
   endtask

   task automatic check_model(input string tag);
      type_iqueue_entry eh;
      eh = (mq.size() != 0) ? mq[0] : '0;
      chk({tag, "_count"},   64'(count_o),            64'(mq.size()));
      chk({tag, "_ready"},   64'(instr_ready_o),      64'(mq.size() != DEPTH));
      chk({tag, "_valid"},   64'(curr_instr_valid_o), 64'(mq.size() != 0));
      chk({tag, "_head"},    64'(curr_instr_o),       64'(eh));
      chk({tag, "_stall"},   64'(stall_cnt_o),        64'(mstall));
      chk({tag, "_timeout"}, 64'(stall_timeout_o),    64'(mstall == SMAX));
      chk({tag, "_err"},     64'(retire_err_o),       64'(merr));
   endtask

   task automatic cyc(input logic vld, input type_iqueue_entry d, input logic ret, input logic fl);
      instr_valid_i = vld;
      instr_i       = d;
      retire_i      = ret;
      flush_i       = fl;
      @(posedge clk);
      model_edge(vld, d, ret, fl);
      #1;
      instr_valid_i = 1'b0;
      retire_i      = 1'b0;
      flush_i       = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      type_iqueue_entry ea, eb, ec, ed, ee, ex, p3;
      logic [31:0] w;
      ea = 32'h1111_0001; eb = 32'h2222_0002; ec = 32'h3333_0003;
      ed = 32'h4444_0004; ee = 32'h5555_0005; ex = 32'h0ABC_DEF1;
      p3 = 32'h7777_7777;

      tbl[0] = '{1'b1, ea, 1'b0, 1'b0, 1, 1'b1, 1'b1, ea, 0};
      tbl[1] = '{1'b1, eb, 1'b0, 1'b0, 2, 1'b1, 1'b1, ea, 1};
      tbl[2] = '{1'b1, ec, 1'b0, 1'b0, 3, 1'b1, 1'b1, ea, 2};
      tbl[3] = '{1'b1, ed, 1'b0, 1'b0, 4, 1'b0, 1'b1, ea, 3};
      tbl[4] = '{1'b1, ee, 1'b1, 1'b0, 3, 1'b1, 1'b1, eb, 0};
      tbl[5] = '{1'b1, ee, 1'b0, 1'b0, 4, 1'b0, 1'b1, eb, 1};
      tbl[6] = '{1'b0, '0, 1'b1, 1'b0, 3, 1'b1, 1'b1, ec, 0};

      reset = 1'b1;
      instr_i = '0; instr_valid_i = 1'b0; retire_i = 1'b0; flush_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(instr_ready_o), 64'(1));
      chk("rst_valid", 64'(curr_instr_valid_o), 64'(0));
      chk("rst_count", 64'(count_o), 64'(0));
      chk("rst_head",  64'(curr_instr_o), 64'(0));
      chk("rst_stall_to", 64'(stall_timeout_o), 64'(0));
      reset = 1'b0;

      // Fill to full, then offer a push alongside a retire while full.
      for (int i = 0; i < 7; i++) begin
         cyc(tbl[i].vld, type_iqueue_entry'(tbl[i].d), tbl[i].ret, tbl[i].fl);
         chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_ready", i), 64'(instr_ready_o), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_valid", i), 64'(curr_instr_valid_o), 64'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_head", i), 64'(curr_instr_o), 64'(tbl[i].e_head));
         chk($sformatf("tbl%0d_stall", i), 64'(stall_cnt_o), 64'(tbl[i].e_stall));
      end

      // Asynchronous reset in the middle of operation.
      cyc(1'b1, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, type_iqueue_entry'($urandom), 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_count", 64'(count_o), 64'(0));
      chk("mid_rst_valid", 64'(curr_instr_valid_o), 64'(0));
      chk("mid_rst_ready", 64'(instr_ready_o), 64'(1));
      chk("mid_rst_head",  64'(curr_instr_o), 64'(0));
      chk("mid_rst_err",   64'(retire_err_o), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      cyc(1'b1, ex, 1'b0, 1'b0);
      chk("post_rst_head",  64'(curr_instr_o), 64'(ex));
      chk("post_rst_valid", 64'(curr_instr_valid_o), 64'(1));

      // Flush beats a same-cycle push and retire.
      cyc(1'b1, type_iqueue_entry'(32'h0000_0AAA), 1'b0, 1'b0);
      cyc(1'b1, p3, 1'b1, 1'b1);
      chk("fl_count", 64'(count_o), 64'(0));
      chk("fl_valid", 64'(curr_instr_valid_o), 64'(0));
      chk("fl_stall", 64'(stall_cnt_o), 64'(0));
      chk("fl_ready", 64'(instr_ready_o), 64'(1));
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("fl_after_valid", 64'(curr_instr_valid_o), 64'(0));
      chk("fl_after_head",  64'(curr_instr_o), 64'(0));

      // Watchdog saturation with a single stuck head.
      cyc(1'b1, ea, 1'b0, 1'b0);
      chk("wd_start", 64'(stall_cnt_o), 64'(0));
      for (int k = 1; k <= 9; k++) begin
         cyc(1'b0, '0, 1'b0, 1'b0);
         chk($sformatf("wd_stall%0d", k), 64'(stall_cnt_o), 64'((k < 7) ? k : 7));
         chk($sformatf("wd_to%0d", k), 64'(stall_timeout_o), 64'(k >= 7));
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("wd_ret_stall", 64'(stall_cnt_o), 64'(0));
      chk("wd_ret_to",    64'(stall_timeout_o), 64'(0));
      chk("wd_ret_count", 64'(count_o), 64'(0));

      // Retire while empty is ignored but latched as an error.
      chk("err_pre", 64'(retire_err_o), 64'(0));
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("err_count", 64'(count_o), 64'(0));
      chk("err_set",   64'(retire_err_o), 64'(1));
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("err_after_flush", 64'(retire_err_o), 64'(1));
      check_model("hand_end");

      // Randomised traffic against the FIFO model.
      do_reset();
      check_model("rnd_rst");
      for (int n = 0; n < 1500; n++) begin
         w = $urandom;
         cyc(($urandom_range(0, 9) < 6), type_iqueue_entry'(w),
             ($urandom_range(0, 9) < (n % 200 < 100 ? 5 : 2)),
             ($urandom_range(0, 99) < 3));
         check_model("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
